// File: rtl/md_unit_if.sv
// ---------------------------------------------------------------------------
// md_unit_if
// Bus between the EX stage and the multiply/divide unit.
//
// Signals:
//   Req    - CP0 exception/interrupt request, kills this cycle's md op
//   MDOp   - 4-bit EX-stage md operation code
//   A, B   - forwarded rs / rt operands
//   Start  - a compute op launches this cycle (combinational)
//   Busy   - a compute op is in flight (registered)
//   HI, LO - committed HI / LO registers
//   MDout  - mfhi / mflo read data (combinational)
//
// Modports:
//   master - pipeline side, drives the op and operands
//   slave  - md unit side, drives the status and results
// ---------------------------------------------------------------------------
interface md_unit_if;
   logic        Req;
   logic [3:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDout;

   modport master (output Req, MDOp, A, B,
                   input  Start, Busy, HI, LO, MDout);
   modport slave  (input  Req, MDOp, A, B,
                   output Start, Busy, HI, LO, MDout);
endinterface

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// EX-stage multiply/divide unit of the 5-stage MIPS pipeline.
// Executes mult/multu/div/divu and mthi/mtlo, and serves mfhi/mflo on MDout.
// Start/Busy feed the hazard logic that stalls md-class instructions in D.
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult-class ops (1..15)
//   DIV_CYCLES  - busy cycles for div/divu (1..15)
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   md    - md_unit_if.slave (Req, MDOp, A, B in; Start, Busy, HI, LO,
//           MDout out)
//
// Optional feature macro: MDU_MADD_EN
//   When defined, MDOp 9..12 are madd/maddu/msub/msubu, which add to or
//   subtract from {HI,LO} the 64-bit product, with MULT_CYCLES latency.
//   When undefined, MDOp 9..12 decode as no-ops.
// ---------------------------------------------------------------------------
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic      clk,
   input logic      reset,
   md_unit_if.slave md
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t      state_q;
   logic [3:0]  count_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] pend_hi_q;
   logic [31:0] pend_lo_q;
   logic        pend_wr_q;

   logic        is_compute;
   logic        is_mult_class;
   logic        busy;
   logic        start;

   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;
`ifdef MDU_MADD_EN
   logic [63:0] acc;
`endif

   // Op decode: which codes are long-latency compute ops, and which of
   // those take the multiply latency.
   always_comb begin
      is_compute    = 1'b0;
      is_mult_class = 1'b0;
      case (md.MDOp)
         OP_MULT, OP_MULTU: begin
            is_compute    = 1'b1;
            is_mult_class = 1'b1;
         end
         OP_DIV, OP_DIVU: is_compute = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            is_compute    = 1'b1;
            is_mult_class = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign busy  = (state_q == ST_RUN);
   assign start = is_compute & ~busy & ~md.Req & ~reset;

   // The whole result is computed in the launch cycle and parked in the
   // pending registers; the busy period only models the latency.
   // res_wr=0 marks a divide by zero, which must leave HI/LO untouched.
   always_comb begin
      a_s    = $signed(md.A);
      b_s    = $signed(md.B);
      prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
      prod_u = {32'd0, md.A} * {32'd0, md.B};
`ifdef MDU_MADD_EN
      acc    = {hi_q, lo_q};
`endif
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b1;
      case (md.MDOp)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            // The most-negative / -1 quotient does not fit, so it is
            // pinned explicitly rather than left to the divider.
            if (md.B == 32'd0) begin
               res_wr = 1'b0;
            end else if (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF) begin
               res_lo = 32'h8000_0000;
               res_hi = 32'd0;
            end else begin
               res_lo = a_s / b_s;
               res_hi = a_s % b_s;
            end
         end
         OP_DIVU: begin
            if (md.B == 32'd0) begin
               res_wr = 1'b0;
            end else begin
               res_lo = md.A / md.B;
               res_hi = md.A % md.B;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {res_hi, res_lo} = acc + prod_s;
         OP_MADDU: {res_hi, res_lo} = acc + prod_u;
         OP_MSUB:  {res_hi, res_lo} = acc - prod_s;
         OP_MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
         default: res_wr = 1'b0;
      endcase
   end

   // Control and HI/LO state. While running, the counter counts down and
   // the edge seen with count==1 commits the pending result, so Busy is
   // high for exactly the loaded number of cycles. mthi/mtlo only land
   // when idle; the hazard logic keeps them away from a busy unit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
         if (count_q == 4'd1) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
            if (pend_wr_q) begin
               hi_q <= pend_hi_q;
               lo_q <= pend_lo_q;
            end
         end else begin
            count_q <= count_q - 4'd1;
         end
      end else if (start) begin
         state_q   <= ST_RUN;
         count_q   <= is_mult_class ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
         pend_hi_q <= res_hi;
         pend_lo_q <= res_lo;
         pend_wr_q <= res_wr;
      end else if (!md.Req) begin
         if (md.MDOp == OP_MTHI) hi_q <= md.A;
         if (md.MDOp == OP_MTLO) lo_q <= md.A;
      end
   end

   assign md.Start = start;
   assign md.Busy  = busy;
   assign md.HI    = hi_q;
   assign md.LO    = lo_q;
   assign md.MDout = (md.MDOp == OP_MFHI) ? hi_q :
                     (md.MDOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Self-checking bench for md_unit. A behavioural model (remaining-cycle
// count plus a pending result computed with 64-bit integer arithmetic) is
// compared against every DUT output each cycle, and a directed sequence pins
// hand-computed values. Randomized traffic follows the directed part.
// Honours MDU_MADD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_md_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk = 1'b0;
   logic reset;
   md_unit_if mdi();

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mdi)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Model state
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] m_pend_hi = 32'd0;
   logic [31:0] m_pend_lo = 32'd0;
   bit          m_pend_wr = 1'b0;
   int          m_left    = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_compute_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   // Result of a compute op as plain integer arithmetic on magnitudes.
   function automatic void model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] base_hi, input logic [31:0] base_lo,
                                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                                        output bit r_wr);
      longint sa, sb, ma, mb, q, r;
      logic [63:0] full, prod;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      full = 64'd0;
      r_wr = 1'b1;
      case (op)
         4'd1: full = 64'(sa * sb);
         4'd2: full = {32'd0, a} * {32'd0, b};
         4'd3, 4'd4: begin
            if (b == 32'd0) begin
               r_wr = 1'b0;
            end else begin
               if (op == 4'd4) begin
                  ma = longint'({32'd0, a});
                  mb = longint'({32'd0, b});
               end else begin
                  ma = (sa < 0) ? -sa : sa;
                  mb = (sb < 0) ? -sb : sb;
               end
               q = ma / mb;
               r = ma % mb;
               if (op == 4'd3) begin
                  if ((sa < 0) != (sb < 0)) q = -q;
                  if (sa < 0) r = -r;
               end
               full = {r[31:0], q[31:0]};
            end
         end
         default: begin
            prod = (op == 4'd9 || op == 4'd11) ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
            full = (op <= 4'd10) ? {base_hi, base_lo} + prod : {base_hi, base_lo} - prod;
         end
      endcase
      r_hi = full[63:32];
      r_lo = full[31:0];
   endfunction

   // Model advances on the same edge as the DUT, from the bench's own inputs.
   always @(posedge clk) begin : model_proc
      logic [31:0] r_hi, r_lo;
      bit          r_wr;
      if (reset) begin
         m_hi      <= 32'd0;
         m_lo      <= 32'd0;
         m_left    <= 0;
         m_pend_wr <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1 && m_pend_wr) begin
            m_hi <= m_pend_hi;
            m_lo <= m_pend_lo;
         end
      end else if (!mdi.Req) begin
         if (is_compute_op(mdi.MDOp)) begin
            model_result(mdi.MDOp, mdi.A, mdi.B, m_hi, m_lo, r_hi, r_lo, r_wr);
            m_pend_hi <= r_hi;
            m_pend_lo <= r_lo;
            m_pend_wr <= r_wr;
            m_left    <= (mdi.MDOp == 4'd3 || mdi.MDOp == 4'd4) ? DIV_N : MULT_N;
         end else if (mdi.MDOp == 4'd7) begin
            m_hi <= mdi.A;
         end else if (mdi.MDOp == 4'd8) begin
            m_lo <= mdi.A;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin : compare_proc
      logic [31:0] exp_start, exp_mdout;
      if (check_en) begin
         exp_start = {31'd0, is_compute_op(mdi.MDOp) && m_left == 0 && !mdi.Req && !reset};
         exp_mdout = (mdi.MDOp == 4'd5) ? m_hi : (mdi.MDOp == 4'd6) ? m_lo : 32'd0;
         checkOutput("model_start", {31'd0, mdi.Start}, exp_start);
         checkOutput("model_busy",  {31'd0, mdi.Busy}, {31'd0, m_left > 0});
         checkOutput("model_hi",    mdi.HI, m_hi);
         checkOutput("model_lo",    mdi.LO, m_lo);
         checkOutput("model_mdout", mdi.MDout, exp_mdout);
      end
   end

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic req);
      mdi.MDOp = op;
      mdi.A    = a;
      mdi.B    = b;
      mdi.Req  = req;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Expect Busy for n cycles, then stop at the negedge of the first idle cycle.
   task automatic busyRun(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput({name, "_busy"}, {31'd0, mdi.Busy}, 32'd1);
         nextCycle();
      end
      @(negedge clk);
      checkOutput({name, "_done"}, {31'd0, mdi.Busy}, 32'd0);
   endtask

   task automatic launch(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      applyStimulus(op, a, b, 1'b0);
      @(negedge clk);
      checkOutput({name, "_start"}, {31'd0, mdi.Start}, 32'd1);
      nextCycle();
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      busyRun(name, n);
      checkOutput({name, "_hi"}, mdi.HI, exp_hi);
      checkOutput({name, "_lo"}, mdi.LO, exp_lo);
      nextCycle();
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] op;
      int r;
      reset = 1'b1;
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      check_en = 1'b1;
      @(negedge clk);
      checkOutput("rst_hi",   mdi.HI, 32'd0);
      checkOutput("rst_lo",   mdi.LO, 32'd0);
      checkOutput("rst_busy", {31'd0, mdi.Busy}, 32'd0);
      nextCycle();

      // Directed sequence with hand-computed results
      launch("mult_neg",  4'd1, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      launch("divu_7_2",  4'd4, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
      launch("div_m7_2",  4'd3, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      applyStimulus(4'd7, 32'h1234_5678, 32'd0, 1'b0);
      nextCycle();
      applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("mthi_hi",    mdi.HI, 32'h1234_5678);
      checkOutput("mfhi_mdout", mdi.MDout, 32'h1234_5678);
      nextCycle();
      launch("div_by_0",  4'd3, 32'd5, 32'd0, DIV_N, 32'h1234_5678, 32'hFFFF_FFFD);
      launch("div_ovf",   4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);

      // multu held for 7 cycles: relaunch in the first idle cycle
      applyStimulus(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      checkOutput("b2b_start0", {31'd0, mdi.Start}, 32'd1);
      for (int i = 1; i <= MULT_N; i++) begin
         nextCycle();
         @(negedge clk);
         checkOutput("b2b_busy",  {31'd0, mdi.Busy}, 32'd1);
         checkOutput("b2b_nostart", {31'd0, mdi.Start}, 32'd0);
      end
      nextCycle();
      @(negedge clk);
      checkOutput("b2b_idle",   {31'd0, mdi.Busy}, 32'd0);
      checkOutput("b2b_start1", {31'd0, mdi.Start}, 32'd1);
      checkOutput("b2b_hi",     mdi.HI, 32'hFFFF_FFFE);
      checkOutput("b2b_lo",     mdi.LO, 32'd1);
      nextCycle();
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      busyRun("b2b_second", MULT_N);
      nextCycle();

      // Req kills a coincident launch
      applyStimulus(4'd1, 32'd3, 32'd4, 1'b1);
      @(negedge clk);
      checkOutput("req_nostart", {31'd0, mdi.Start}, 32'd0);
      nextCycle();
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("req_busy", {31'd0, mdi.Busy}, 32'd0);
      checkOutput("req_hi",   mdi.HI, 32'hFFFF_FFFE);
      checkOutput("req_lo",   mdi.LO, 32'd1);
      nextCycle();

      // Req during cycle 3 of an in-flight mult does not stop the commit
      applyStimulus(4'd1, 32'd3, 32'd4, 1'b0);
      @(negedge clk);
      checkOutput("reqmid_start", {31'd0, mdi.Start}, 32'd1);
      for (int i = 1; i <= MULT_N; i++) begin
         nextCycle();
         applyStimulus(4'd0, 32'd0, 32'd0, (i == 3));
         @(negedge clk);
         checkOutput("reqmid_busy", {31'd0, mdi.Busy}, 32'd1);
      end
      nextCycle();
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("reqmid_done", {31'd0, mdi.Busy}, 32'd0);
      checkOutput("reqmid_hi",   mdi.HI, 32'd0);
      checkOutput("reqmid_lo",   mdi.LO, 32'd12);
      nextCycle();

      // Reset during cycle 4 of a div
      applyStimulus(4'd3, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      checkOutput("rstmid_start", {31'd0, mdi.Start}, 32'd1);
      nextCycle();
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      repeat (3) nextCycle();
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_busy", {31'd0, mdi.Busy}, 32'd0);
      checkOutput("rstmid_hi",   mdi.HI, 32'd0);
      checkOutput("rstmid_lo",   mdi.LO, 32'd0);
      nextCycle();

`ifdef MDU_MADD_EN
      applyStimulus(4'd7, 32'd0, 32'd0, 1'b0);
      nextCycle();
      applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
      nextCycle();
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("madd_base_lo", mdi.LO, 32'hFFFF_FFFF);
      nextCycle();
      launch("maddu_carry", 4'd10, 32'd1, 32'd1, MULT_N, 32'd1, 32'd0);
`endif

      // Randomized traffic checked by the model each cycle
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      op = 4'd0;
         else if (r < 60) op = 4'($urandom_range(1, 4));
         else if (r < 70) op = 4'($urandom_range(5, 6));
         else if (r < 80) op = 4'($urandom_range(7, 8));
         else if (r < 88) op = 4'($urandom_range(9, 12));
         else             op = 4'($urandom_range(0, 15));
         applyStimulus(op, rand_val(), rand_val(), ($urandom_range(0, 15) == 0));
         reset = ($urandom_range(0, 299) == 0);
         nextCycle();
      end
      reset = 1'b0;
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      repeat (DIV_N + 2) nextCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline with CP0 exceptions.
- Executes mult/multu/div/divu and mthi/mtlo, and supplies HI/LO for mfhi/mflo.
- Produces the Start and Busy signals that the hazard/stall logic consumes to stall D-stage md-class instructions.
- Result data for mfhi/mflo leaves on MDout, which travels down the pipe as the MDdata_M forwarding source.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous active-high reset
- Req  input  1  exception/interrupt request from CP0; kills the EX-stage md operation issued this cycle
- MDOp  input  4  EX-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-12 see Optional Feature, others = none
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Start  output  1  combinational; high when a compute op (1-4, or 9-12 if enabled) launches this cycle
- Busy  output  1  registered; high while a compute op is in flight
- HI  output  32  HI register
- LO  output  32  LO register
- MDout  output  32  combinational; HI if MDOp=5, LO if MDOp=6, else 0

Behaviour:
- Reset: HI=0, LO=0, Busy=0, counter=0, pending results cleared; Start and MDout follow from the cleared state.
- Launch:
  - Start = (MDOp is compute) & !Busy & !Req & !reset.
  - On a Start edge, capture operands, compute pHI/pLO into pending registers, load counter with MULT_CYCLES or DIV_CYCLES, set Busy=1.
- Busy period:
  - Counter decrements each cycle while Busy.
  - When counter reaches 1, the next edge writes pHI/pLO to HI/LO and clears Busy.
  - Busy is high for exactly N cycles after the Start cycle (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible in the first cycle with Busy=0.
- mult: {HI,LO} = signed A*B. multu: unsigned product.
- div: LO = signed quotient (truncate toward zero); HI = remainder, with the sign of the dividend. divu: unsigned quotient and remainder.
- Divide by zero: HI/LO are not modified when the op completes. Busy still runs the full DIV_CYCLES.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo:
  - When !Busy & !Req, write A to HI/LO at the edge.
  - When Busy, the write is ignored; the hazard logic guarantees this case does not occur.
  - Any compute op presented while Busy does not launch; Start stays 0 and in-flight state is unchanged.
- mfhi/mflo: MDout reads the committed HI/LO (not pending) with zero latency.
- Req:
  - Suppresses only the op in the current cycle: no Start, no mthi/mtlo write.
  - An already in-flight op runs to completion and commits, because it was issued before the excepting instruction.
- Reset mid-operation: aborts the op; pending results are discarded and HI/LO are zeroed.
- Simultaneous commit edge and new compute op: Busy is still 1 that cycle, so there is no launch. The op launches the following cycle (Start=1).

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MDOp 9 madd, 10 maddu, 11 msub, 12 msubu are compute ops with MULT_CYCLES latency.
  - The operation is {HI,LO} ± the signed/unsigned 64-bit product, modulo 2^64.
  - The base value is the HI/LO value at Start.
- Not defined: MDOp 9-12 decode as none. Start=0 and no state change.

Test Plan:
- Reset, then MDOp=1 with A=0xFFFFFFFE, B=3 for one cycle -> Start=1 that cycle; Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MDOp=4 with A=7, B=2 -> Busy=1 for 10 cycles, then HI=1, LO=3. MDOp=3 with A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MDOp=7 with A=0x12345678, then MDOp=5 next cycle -> HI=0x12345678 and MDout=0x12345678. Next, MDOp=3 with B=0 -> Busy runs 10 cycles and HI/LO are unchanged.
- Back-to-back: MDOp=2 (A=0xFFFFFFFF, B=0xFFFFFFFF) held for 7 cycles -> first launch produces HI=0xFFFFFFFE, LO=1 after 5 cycles. Second Start occurs in the first cycle with Busy=0.
- Req=1 coincident with MDOp=1 -> Start=0, Busy stays 0, HI/LO unchanged. With Req=1 during cycle 3 of an in-flight mult -> result still commits at cycle 5.
- Assert reset during cycle 4 of a div -> HI=LO=0 and Busy=0 the next cycle. With MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, then MDOp=10 with A=1, B=1 -> HI=1, LO=0 after 5 cycles.
